// File: rtl/adc_dec_pkg.sv
// Constants and types shared by the ADC decimation chain (CIC front end, hb1, hb2).
package adc_dec_pkg;
    localparam int CIC_IN_W  = 5;
    localparam int CIC_N     = 5;
    localparam int CIC_R     = 64;
    localparam int CIC_PH_W  = $clog2(CIC_R);
    // Full-precision growth: IN_W + N*log2(R)
    localparam int ADC_DAT_W = CIC_IN_W + CIC_N * CIC_PH_W;

    typedef logic signed [ADC_DAT_W-1:0] adc_dat_t;

    typedef struct packed {
        logic     vld;
        adc_dat_t dat;
    } adc_smp_t;
endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb (differentiator, M=1) on the decimated stream; registered output.
module cic_comb_stage #(
    parameter int OUT_W = 35
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_i,
    input  logic [OUT_W-1:0] dat_i,
    output logic             vld_o,
    output logic [OUT_W-1:0] dat_o
);
    logic [OUT_W-1:0] y_q, dly_q;
    logic             vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            dly_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_i;
            if (vld_i) begin
                y_q   <= dat_i - dly_q;
                dly_q <= dat_i;
            end
        end
    end

    assign vld_o = vld_q;
    assign dat_o = y_q;
endmodule

// File: rtl/cic5_decimator.sv
// sinc^N CIC decimator: strobed integrators and phase counter, pipelined comb chain.
module cic5_decimator
    import adc_dec_pkg::*;
#(
    parameter int IN_W  = CIC_IN_W,
    parameter int N     = CIC_N,
    parameter int R     = CIC_R,
    parameter int OUT_W = ADC_DAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_vld_in,
    input  logic [IN_W-1:0]  dat_in,
    input  logic             sync,
    output logic             clk_vld_out,
    output logic [OUT_W-1:0] dat_out
);
    localparam int PH_W = $clog2(R);

    logic [N-1:0][OUT_W-1:0] integ_q, integ_d;
    logic [PH_W-1:0]         ph_q, ph_d;
    logic [OUT_W-1:0]        cap_q;
    logic [OUT_W-1:0]        dat_out_q;
    logic                    vld_out_q;
    logic                    dec_evt;

    logic [N:0]              vld_pipe;
    logic [N:0][OUT_W-1:0]   comb_dat;

    assign dec_evt = clk_vld_in && !sync && (ph_q == PH_W'(R-1));

    // Each stage accumulates the previous stage's pre-edge value; wrap is intended.
    always_comb begin
        integ_d = integ_q;
        if (clk_vld_in) begin
            integ_d[0] = integ_q[0] + {{(OUT_W-IN_W){dat_in[IN_W-1]}}, dat_in};
            for (int k = 1; k < N; k++)
                integ_d[k] = integ_q[k] + integ_q[k-1];
        end
    end

    always_comb begin
        ph_d = ph_q;
        if (sync)
            ph_d = '0;
        else if (clk_vld_in)
            ph_d = ph_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            integ_q     <= '0;
            ph_q        <= '0;
            cap_q       <= '0;
            vld_pipe[0] <= 1'b0;
        end else begin
            integ_q     <= integ_d;
            ph_q        <= ph_d;
            vld_pipe[0] <= dec_evt;
            if (dec_evt)
                cap_q <= integ_q[N-1];
        end
    end

    assign comb_dat[0] = cap_q;

    for (genvar k = 1; k <= N; k++) begin : g_comb
        cic_comb_stage #(.OUT_W(OUT_W)) u_comb (
            .clk   (clk),
            .rst   (rst),
            .vld_i (vld_pipe[k-1]),
            .dat_i (comb_dat[k-1]),
            .vld_o (vld_pipe[k]),
            .dat_o (comb_dat[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dat_out_q <= '0;
            vld_out_q <= 1'b0;
        end else begin
            vld_out_q <= vld_pipe[N];
            if (vld_pipe[N])
                dat_out_q <= comb_dat[N];
        end
    end

    assign clk_vld_out = vld_out_q;
    assign dat_out     = dat_out_q;
endmodule
